// File: rtl/nivel_aguas_ctrl_if.sv
// Sensor/operator inputs and indicator outputs of the reservoir level controller.
// The controller uses the slave modport; the surrounding logic uses master.
interface nivel_aguas_ctrl_if #(
  parameter int EVT_W = 8
);
  logic [1:0]       sensor;
  logic             ack;
  logic [1:0]       level;
  logic [7:0]       seg;
  logic             pump;
  logic             spill;
  logic             alarm;
  logic [1:0]       state;
  logic [EVT_W-1:0] events;

  modport master (
    output sensor, ack,
    input  level, seg, pump, spill, alarm, state, events
  );

  modport slave (
    input  sensor, ack,
    output level, seg, pump, spill, alarm, state, events
  );
endinterface

// File: rtl/nivel_aguas_ctrl.sv
// Reservoir level controller: sensor debounce, fill-pump/spillway FSM with pump watchdog,
// fault alarm, 7-seg glyph and saturating change counter. Option macro: AGUAS_AUTO_CLEAR_EN.
module nivel_aguas_ctrl #(
  parameter int DEBOUNCE     = 4,
  parameter int PUMP_TIMEOUT = 200,
  parameter int EVT_W        = 8
) (
  input  logic              clk_2,
  input  logic              reset_n,
  nivel_aguas_ctrl_if.slave bus
);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_SPILL  = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam logic [1:0] LV_HIGH   = 2'b00;
  localparam logic [1:0] LV_NORM   = 2'b01;
  localparam logic [1:0] LV_LOW    = 2'b10;
  localparam logic [1:0] LV_DEF    = 2'b11;

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int TMR_W = $clog2(PUMP_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PUMP_TIMEOUT - 1);
  localparam logic [EVT_W-1:0] EVT_MAX  = '1;

  logic [1:0]       s_q;
  logic [1:0]       cand;
  logic [1:0]       cand_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic [1:0]       level_q;
  logic [1:0]       state_q;
  logic [1:0]       state_next;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_next;
  logic [EVT_W-1:0] events_q;
  logic [7:0]       seg_d;

`ifdef AGUAS_AUTO_CLEAR_EN
  // Remembers that the current FAULT came from the pump watchdog, which only clears once
  // the level has left "low".
  logic to_flag;
  logic to_next;
`endif

  // The run length counts the registered sample itself, so a steady code lands on level
  // DEBOUNCE+1 edges after it first appears at the pins.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (s_q == cand) begin
      if (cnt != CNT_MAX) cnt_next = cnt + 1'b1;
    end else begin
      cand_next = s_q;
      cnt_next  = CNT_W'(1);
    end
    accept = (cnt_next == CNT_MAX) && (cand_next != level_q);
  end

  always_comb begin
    state_next = state_q;
    timer_next = '0;
`ifdef AGUAS_AUTO_CLEAR_EN
    to_next    = 1'b0;
`endif
    if (level_q == LV_DEF) begin
      state_next = ST_FAULT;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (level_q == LV_LOW)       state_next = ST_FILL;
          else if (level_q == LV_HIGH) state_next = ST_SPILL;
        end
        ST_FILL: begin
          if (level_q == LV_NORM)      state_next = ST_NORMAL;
          else if (level_q == LV_HIGH) state_next = ST_SPILL;
          else if (timer == TMR_LAST) begin
            state_next = ST_FAULT;
`ifdef AGUAS_AUTO_CLEAR_EN
            to_next    = 1'b1;
`endif
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        ST_SPILL: begin
          if (level_q == LV_NORM)      state_next = ST_NORMAL;
          else if (level_q == LV_LOW)  state_next = ST_FILL;
        end
        default: begin
`ifdef AGUAS_AUTO_CLEAR_EN
          if (to_flag && level_q == LV_LOW) to_next = 1'b1;
          else                              state_next = ST_NORMAL;
`else
          if (bus.ack) state_next = ST_NORMAL;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      s_q      <= LV_NORM;
      cand     <= LV_NORM;
      cnt      <= '0;
      level_q  <= LV_NORM;
      state_q  <= ST_NORMAL;
      timer    <= '0;
      events_q <= '0;
`ifdef AGUAS_AUTO_CLEAR_EN
      to_flag  <= 1'b0;
`endif
    end else begin
      s_q     <= bus.sensor;
      cand    <= cand_next;
      cnt     <= cnt_next;
      state_q <= state_next;
      timer   <= timer_next;
`ifdef AGUAS_AUTO_CLEAR_EN
      to_flag <= to_next;
`endif
      if (accept) begin
        level_q <= cand_next;
        if (events_q != EVT_MAX) events_q <= events_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (level_q)
      LV_HIGH: seg_d = 8'h77;
      LV_NORM: seg_d = 8'h54;
      LV_LOW:  seg_d = 8'h7c;
      default: seg_d = 8'h5e;
    endcase
  end

  assign bus.level  = level_q;
  assign bus.seg    = seg_d;
  assign bus.state  = state_q;
  assign bus.pump   = (state_q == ST_FILL);
  assign bus.spill  = (state_q == ST_SPILL);
  assign bus.alarm  = (state_q == ST_FAULT);
  assign bus.events = events_q;

endmodule

// File: tb/tb_nivel_aguas_ctrl.sv
// Bench for nivel_aguas_ctrl: directed scenarios plus random sensor/ack/reset traffic,
// all compared every cycle against a sample-history reference model.
module tb_nivel_aguas_ctrl;

  localparam int DEBOUNCE     = 4;
  localparam int PUMP_TIMEOUT = 16;
  localparam int EVT_W        = 2;

  logic clk_2;
  logic reset_n;
  int   checks;
  int   failures;

  nivel_aguas_ctrl_if #(.EVT_W(EVT_W)) bus ();

  nivel_aguas_ctrl #(
    .DEBOUNCE    (DEBOUNCE),
    .PUMP_TIMEOUT(PUMP_TIMEOUT),
    .EVT_W       (EVT_W)
  ) dut (
    .clk_2  (clk_2),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Reference model: level is whatever code filled the last DEBOUNCE registered samples;
  // the FSM counts how many cycles it has been showing FILL.
  logic [1:0] hist[$];
  int         m_level;
  int         m_state;
  int         m_fill_cycles;
  int         m_events;
  bit         m_timeout_fault;
  logic [7:0] glyph[4];

  task automatic model_step(input logic [1:0] s, input logic a, input logic rn);
    int  ns;
    bit  steady;
    if (!rn) begin
      hist.delete();
      hist.push_back(2'b01);
      m_level = 1; m_state = 0; m_fill_cycles = 0; m_events = 0; m_timeout_fault = 0;
      return;
    end
    ns = m_state;
    if (m_level == 3) begin
      ns = 3;
      m_timeout_fault = 0;
    end else if (m_state == 0) begin
      if (m_level == 2) ns = 1;
      else if (m_level == 0) ns = 2;
    end else if (m_state == 1) begin
      if (m_level == 1) ns = 0;
      else if (m_level == 0) ns = 2;
      else if (m_fill_cycles == PUMP_TIMEOUT) begin
        ns = 3;
        m_timeout_fault = 1;
      end
    end else if (m_state == 2) begin
      if (m_level == 1) ns = 0;
      else if (m_level == 2) ns = 1;
    end else begin
`ifdef AGUAS_AUTO_CLEAR_EN
      if (!(m_timeout_fault && m_level == 2)) ns = 0;
`else
      if (a) ns = 0;
`endif
      if (ns == 0) m_timeout_fault = 0;
    end
    if (ns == 1) m_fill_cycles = (m_state == 1) ? m_fill_cycles + 1 : 1;
    else         m_fill_cycles = 0;
    m_state = ns;

    steady = (hist.size() >= DEBOUNCE);
    if (steady)
      for (int i = 0; i < DEBOUNCE; i++)
        if (hist[hist.size()-1-i] !== hist[hist.size()-1]) steady = 0;
    if (steady && int'(hist[hist.size()-1]) != m_level) begin
      m_level = int'(hist[hist.size()-1]);
      if (m_events < (1 << EVT_W) - 1) m_events++;
    end
    hist.push_back(s);
    if (hist.size() > DEBOUNCE + 1) void'(hist.pop_front());
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] s, input logic a, input logic rn);
    bus.sensor = s;
    bus.ack    = a;
    reset_n    = rn;
    @(posedge clk_2);
    model_step(s, a, rn);
    #1;
    check_output("level",  32'(bus.level),  32'(m_level));
    check_output("seg",    32'(bus.seg),    32'(glyph[m_level]));
    check_output("state",  32'(bus.state),  32'(m_state));
    check_output("pump",   32'(bus.pump),   32'(m_state == 1));
    check_output("spill",  32'(bus.spill),  32'(m_state == 2));
    check_output("alarm",  32'(bus.alarm),  32'(m_state == 3));
    check_output("events", 32'(bus.events), 32'(m_events));
  endtask

  task automatic hold(input logic [1:0] s, input logic a, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(s, a, 1'b1);
  endtask

  initial begin
    logic [1:0] code;
    int         len;
    checks   = 0;
    failures = 0;
    glyph[0] = 8'h77; glyph[1] = 8'h54; glyph[2] = 8'h7c; glyph[3] = 8'h5e;
    bus.sensor = 2'b00;
    bus.ack    = 1'b0;
    reset_n    = 1'b0;
    @(negedge clk_2);

    // T1: reset with a non-default sensor code
    apply_stimulus(2'b00, 1'b0, 1'b0);
    apply_stimulus(2'b00, 1'b0, 1'b0);
    check_output("t1_seg", 32'(bus.seg), 32'h54);
    hold(2'b01, 1'b0, 3);

    // T2: acceptance latency of a held code
    hold(2'b10, 1'b0, 4);
    check_output("t2_level_before", 32'(bus.level), 32'h1);
    hold(2'b10, 1'b0, 1);
    check_output("t2_level_edge5", 32'(bus.level), 32'h2);
    check_output("t2_pump_not_yet", 32'(bus.pump), 32'h0);
    hold(2'b10, 1'b0, 1);
    check_output("t2_pump_on", 32'(bus.pump), 32'h1);
    hold(2'b01, 1'b0, 5);
    check_output("t2_level_back", 32'(bus.level), 32'h1);
    hold(2'b01, 1'b0, 1);
    check_output("t2_pump_off", 32'(bus.pump), 32'h0);

    // T3: short glitch is ignored
    hold(2'b00, 1'b0, 3);
    hold(2'b01, 1'b0, 6);
    check_output("t3_events", 32'(bus.events), 32'h2);

    // T4: pump watchdog and acknowledge
    hold(2'b10, 1'b0, 6 + PUMP_TIMEOUT + 1);
    hold(2'b10, 1'b1, 1);
    hold(2'b10, 1'b0, 2);
    hold(2'b10, 1'b0, PUMP_TIMEOUT + 2);
    hold(2'b01, 1'b1, 8);

    // T5: defective sensor
    hold(2'b11, 1'b0, 7);
    check_output("t5_seg", 32'(bus.seg), 32'h5e);
    hold(2'b11, 1'b1, 2);
    hold(2'b01, 1'b0, 7);
    hold(2'b01, 1'b1, 2);
    hold(2'b01, 1'b0, 2);

    // T6: counter saturation, then reset in the middle of FILL
    apply_stimulus(2'b01, 1'b0, 1'b0);
    hold(2'b10, 1'b0, 6);
    hold(2'b01, 1'b0, 6);
    hold(2'b00, 1'b0, 6);
    hold(2'b01, 1'b0, 6);
    hold(2'b10, 1'b0, 6);
    check_output("t6_events_sat", 32'(bus.events), 32'h3);
    check_output("t6_pump_fill", 32'(bus.pump), 32'h1);
    apply_stimulus(2'b10, 1'b0, 1'b0);
    check_output("t6_pump_reset", 32'(bus.pump), 32'h0);
    check_output("t6_events_reset", 32'(bus.events), 32'h0);

    // Random traffic: held codes of random length, sporadic ack and reset
    for (int seg_i = 0; seg_i < 80; seg_i++) begin
      code = 2'($urandom_range(0, 3));
      len  = $urandom_range(1, 8);
      for (int c = 0; c < len; c++)
        apply_stimulus(code, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 59) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
